cgra_cfg_sequencer: RTL

CGRA_CFG_SEQUENCER -- requirements
Module: cgra_cfg_sequencer

---
 rtl/cgra_cfg_pkg.sv | 27 ++
 rtl/cgra_cfg_sequencer_if.sv | 29 ++
 rtl/cgra_cfg_fifo.sv | 56 +++++
 rtl/cgra_cfg_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Purpose: shared types and widths for the CGRA configuration sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cgra_cfg_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WSETUP,
    ST_WSTROBE,
    ST_WHOLD,
    ST_RSETUP,
    ST_RWAIT,
    ST_RDONE
  } cfg_state_e;

  // One buffered config write: address in the upper half, data in the lower.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cfg_entry_t;

  localparam int ENTRY_W = $bits(cfg_entry_t);

endpackage

// File: rtl/cgra_cfg_sequencer_if.sv
// Purpose: CGRA-side configuration port (address/data/strobe/read enable/read data).
// Latency: n/a (wiring only).
// Backpressure: none; the CGRA port has fixed timing set by the sequencer.
interface cgra_cfg_sequencer_if;
  import cgra_cfg_pkg::*;

  logic [ADDR_W-1:0] cgra_config_addr_o;
  logic [DATA_W-1:0] cgra_config_data_o;
  logic              cgra_config_write_o;
  logic              cgra_config_read_o;
  logic [DATA_W-1:0] cgra_read_data_i;

  modport master (
    output cgra_config_addr_o,
    output cgra_config_data_o,
    output cgra_config_write_o,
    output cgra_config_read_o,
    input  cgra_read_data_i
  );

  modport slave (
    input  cgra_config_addr_o,
    input  cgra_config_data_o,
    input  cgra_config_write_o,
    input  cgra_config_read_o,
    output cgra_read_data_i
  );

endinterface

// File: rtl/cgra_cfg_fifo.sv
// Purpose: synchronous FIFO buffering config write commands.
// Latency: head entry visible combinationally the cycle after the first push.
// Backpressure: a push into a full FIFO is accepted only alongside a pop, otherwise dropped.
module cgra_cfg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cgra_cfg_sequencer.sv
// Purpose: serialises CSR config writes and reads onto the CGRA config port.
// Latency: write strobe 1+SETUP_CYC cycles after the pulse; read data valid 1+READ_LAT cycles after read start.
// Backpressure: none upstream; FIFO_DEPTH writes are buffered, excess pushes are dropped and flagged on ovf_o.
module cgra_cfg_sequencer
  import cgra_cfg_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [ADDR_W-1:0]    cfg_addr_i,
  input  logic [DATA_W-1:0]    cfg_wdata_i,
  input  logic                 cfg_write_i,
  input  logic                 cfg_read_i,
  output logic [DATA_W-1:0]    cfg_rdata_o,
  output logic                 cfg_rdata_valid_o,
  output logic                 busy_o,
  output logic                 ovf_o,
  cgra_cfg_sequencer_if.master cgra
);
  localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] READ_LD  = 4'(READ_LAT - 1);

  cfg_state_e        state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic              wr_q;
  logic              rd_q;
  logic              vld_q;
  logic              pending_q;
  logic              read_q;
  logic              ovf_q;

  cfg_entry_t        push_entry;
  cfg_entry_t        head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              read_rise;

  assign push_entry = '{addr: cfg_addr_i, data: cfg_wdata_i};
  // The FSM only ever pops from IDLE, so the pop is known before the edge.
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign read_rise  = cfg_read_i && !read_q;

  cgra_cfg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .push      (cfg_write_i),
    .wdata     (push_entry),
    .pop       (fifo_pop),
    .rdata     (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cgra.cgra_config_addr_o  = addr_q;
  assign cgra.cgra_config_data_o  = data_q;
  assign cgra.cgra_config_write_o = wr_q;
  assign cgra.cgra_config_read_o  = rd_q;

  assign cfg_rdata_o       = rdata_q;
  assign cfg_rdata_valid_o = vld_q;
  assign ovf_o             = ovf_q;
  assign busy_o            = (state_q != ST_IDLE) || (fifo_count != '0) || pending_q;

  // Sticky overflow: a push that finds the FIFO full with no same-edge pop is lost.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ovf_q <= 1'b0;
    end else if (cfg_write_i && fifo_full && !fifo_pop) begin
      ovf_q <= 1'b1;
    end
  end

  // Sequencer FSM: drains buffered writes first, then services a pending read.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      vld_q     <= 1'b0;
      pending_q <= 1'b0;
      read_q    <= 1'b0;
    end else begin
      read_q <= cfg_read_i;
      if (read_rise) pending_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            addr_q  <= head_entry.addr;
            data_q  <= head_entry.data;
            cnt_q   <= SETUP_LD;
            state_q <= ST_WSETUP;
          end else if (pending_q) begin
            addr_q  <= cfg_addr_i;
            rd_q    <= 1'b1;
            state_q <= ST_RSETUP;
          end
        end
        ST_WSETUP: begin
          if (cnt_q == '0) begin
            wr_q    <= 1'b1;
            state_q <= ST_WSTROBE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WSTROBE: begin
          wr_q    <= 1'b0;
          state_q <= ST_WHOLD;
        end
        ST_WHOLD: begin
          state_q <= ST_IDLE;
        end
        ST_RSETUP: begin
          cnt_q   <= READ_LD;
          state_q <= ST_RWAIT;
        end
        ST_RWAIT: begin
          if (cnt_q == '0) begin
            rdata_q   <= cgra.cgra_read_data_i;
            vld_q     <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= ST_RDONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RDONE: begin
          // Hold the read enable until the CSR stage releases its request.
          if (!cfg_read_i) begin
            rd_q    <= 1'b0;
            vld_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
